// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx -- parallel-in, serial-out bit transmitter
//
// Accepts WIDTH-bit words over a valid/ready handshake and shifts them out
// MSB-first, one bit per clock, on a registered serial output. A one-word
// holding register lets consecutive frames run back to back with no idle
// cycle between them.
//
// Optional feature macro: PISO_TX_PARITY_EN
//   defined   -> one even-parity bit (XOR of the word) follows the data bits
//                and is flagged by sout_last
//   undefined -> data bit 0 is the final bit of the frame
//
// Parameters:
//   WIDTH       data word width, 2..32 (default 8)
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         parallel word to transmit
//   din_valid   din is presented
//   din_ready   registered; a word can be accepted this cycle
//   sout        registered serial data bit (0 while idle)
//   sout_valid  registered; sout carries a frame bit this cycle
//   sout_last   registered; this is the final bit of the frame
//   busy        registered; a frame is in progress
// -----------------------------------------------------------------------------
module piso_tx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   output logic             busy
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] hold_reg, hold_next;
   logic             hold_full_reg, hold_full_next;
`ifdef PISO_TX_PARITY_EN
   logic             par_reg, par_next;
`endif

   logic sout_reg, sout_next;
   logic sout_valid_reg, sout_valid_next;
   logic sout_last_reg, sout_last_next;
   logic busy_reg, busy_next;
   logic din_ready_reg, din_ready_next;

   logic accept;
   logic frame_end;

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         shift_reg      <= '0;
         cnt_reg        <= '0;
         hold_reg       <= '0;
         hold_full_reg  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
         par_reg        <= 1'b0;
`endif
         sout_reg       <= 1'b0;
         sout_valid_reg <= 1'b0;
         sout_last_reg  <= 1'b0;
         busy_reg       <= 1'b0;
         din_ready_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         shift_reg      <= shift_next;
         cnt_reg        <= cnt_next;
         hold_reg       <= hold_next;
         hold_full_reg  <= hold_full_next;
`ifdef PISO_TX_PARITY_EN
         par_reg        <= par_next;
`endif
         sout_reg       <= sout_next;
         sout_valid_reg <= sout_valid_next;
         sout_last_reg  <= sout_last_next;
         busy_reg       <= busy_next;
         din_ready_reg  <= din_ready_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic. state_reg/shift_reg/cnt_reg describe the bit being
   // driven in the current cycle; the output flops are loaded from the
   // *next* state so that they line up with it one cycle later.
   // ------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      shift_next     = shift_reg;
      cnt_next       = cnt_reg;
      hold_next      = hold_reg;
      hold_full_next = hold_full_reg;
`ifdef PISO_TX_PARITY_EN
      par_next       = par_reg;
`endif
      frame_end      = 1'b0;
      accept         = din_valid & din_ready_reg;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               shift_next = din;
               cnt_next   = '0;
               state_next = SHIFT;
`ifdef PISO_TX_PARITY_EN
               par_next   = 1'b0;
`endif
            end
         end
         SHIFT: begin
            shift_next = {shift_reg[WIDTH-2:0], 1'b0};
            cnt_next   = cnt_reg + 1'b1;
`ifdef PISO_TX_PARITY_EN
            par_next   = par_reg ^ shift_reg[WIDTH-1];
`endif
            if (accept) begin
               hold_next      = din;
               hold_full_next = 1'b1;
            end
            if (cnt_reg == LAST_IDX) begin
`ifdef PISO_TX_PARITY_EN
               state_next = PARITY;
`else
               frame_end  = 1'b1;
`endif
            end
         end
`ifdef PISO_TX_PARITY_EN
         PARITY: begin
            if (accept) begin
               hold_next      = din;
               hold_full_next = 1'b1;
            end
            frame_end = 1'b1;
         end
`endif
         default: state_next = IDLE;
      endcase

      // End of frame: chain straight into the held word. A word accepted on
      // this very edge (only possible with the holding register empty) is
      // loaded directly so it is not stranded in the holding register.
      if (frame_end) begin
         if (hold_full_reg) begin
            shift_next     = hold_reg;
            hold_full_next = 1'b0;
            cnt_next       = '0;
            state_next     = SHIFT;
`ifdef PISO_TX_PARITY_EN
            par_next       = 1'b0;
`endif
         end else if (accept) begin
            shift_next     = din;
            hold_full_next = 1'b0;
            cnt_next       = '0;
            state_next     = SHIFT;
`ifdef PISO_TX_PARITY_EN
            par_next       = 1'b0;
`endif
         end else begin
            state_next = IDLE;
         end
      end

      // Registered outputs derived from the upcoming state.
      sout_next       = 1'b0;
      sout_last_next  = 1'b0;
      sout_valid_next = (state_next != IDLE);
      busy_next       = (state_next != IDLE);
      din_ready_next  = ~hold_full_next;
      if (state_next == SHIFT) begin
         sout_next = shift_next[WIDTH-1];
`ifndef PISO_TX_PARITY_EN
         sout_last_next = (cnt_next == LAST_IDX);
`endif
      end
`ifdef PISO_TX_PARITY_EN
      if (state_next == PARITY) begin
         sout_next      = par_next;
         sout_last_next = 1'b1;
      end
`endif
   end

   assign sout       = sout_reg;
   assign sout_valid = sout_valid_reg;
   assign sout_last  = sout_last_reg;
   assign busy       = busy_reg;
   assign din_ready  = din_ready_reg;

endmodule
